lane_draw_scheduler: RTL and testbench

- Sequences the VGA pixel writer for the three falling-tile lanes.
- On each frame tick it snapshots the 360-bit lane bitmap (3 lanes x 120 rows), then walks every lane/row/column and issues one plot per cycle to the VGA adapter.
- Sits between the lane shift register (updated on the 0.02 s tick) and the VGA adapter's x/y/colour/plot inputs.
- The drawn frame is never torn by a mid-scan lane shift.

---
 rtl/lane_draw_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_lane_draw_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_draw_scheduler.sv
// ---------------------------------------------------------------------------
// lane_draw_scheduler
//   Drives the VGA pixel writer for the three falling-tile lanes. A frame_tick
//   snapshots the 360-bit lane bitmap and then emits one plot per cycle,
//   walking col (fastest), row, then lane. Because the scan works from the
//   snapshot, a lane shift that lands mid-scan never tears the frame.
//
// Ports
//   clock        system clock
//   resetn       asynchronous active-low reset
//   frame_tick   one-cycle redraw request
//   lane_data    lane bitmap, lane k row r at bit k*120+r (row 0 = top)
//   pause        stalls the scan while high (VGA shared with another writer)
//   x, y, colour pixel coordinates and colour
//   plot         pixel write strobe
//   busy         high while a scan is in progress
//   frame_done   one-cycle pulse after the last pixel
//   missed_tick  sticky flag: a frame_tick arrived while busy
//
// Optional feature macro: LANE_DRAW_DIRTY_SKIP_EN
//   When defined, rows that are unchanged since the last completed frame
//   cost one silent cycle instead of LANE_W plots.
// ---------------------------------------------------------------------------
module lane_draw_scheduler #(
    parameter int         LANE_W     = 8,
    parameter int         LANE_X0    = 50,
    parameter int         LANE_PITCH = 20,
    parameter logic [2:0] COL_DO     = 3'b100,
    parameter logic [2:0] COL_RE     = 3'b010,
    parameter logic [2:0] COL_MI     = 3'b001,
    parameter logic [2:0] COL_BG     = 3'b000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         frame_tick,
    input  logic [359:0] lane_data,
    input  logic         pause,
    output logic [7:0]   x,
    output logic [6:0]   y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         frame_done,
    output logic         missed_tick
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DRAW = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int               COL_W     = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LANE_W - 1);
    localparam logic [6:0]       ROW_LAST  = 7'd119;
    localparam logic [1:0]       LANE_LAST = 2'd2;
    localparam logic [7:0]       X0        = 8'(LANE_X0);
    localparam logic [7:0]       PITCH     = 8'(LANE_PITCH);

    logic [1:0]       state_q, state_d;
    logic [1:0]       lane_q, lane_d;
    logic [6:0]       row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [359:0]     snap_q, snap_d;
    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [2:0]       colour_q, colour_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             missed_q, missed_d;

    logic [359:0]     src_vec_s;
    logic [8:0]       bit_idx_s;
    logic             src_bit_s;
    logic [7:0]       x_s;
    logic [2:0]       lane_col_s;
    logic             skip_s;
    logic             step_s;

    // Pixel datapath: bitmap bit, x coordinate and tile colour for the current counters.
    always_comb begin
        // The first pixel is issued in LOAD, before snap_q holds the bitmap,
        // so LOAD reads lane_data directly (the same value snap_q captures).
        if (state_q == S_LOAD) begin
            src_vec_s = lane_data;
        end else begin
            src_vec_s = snap_q;
        end
        bit_idx_s = ({7'd0, lane_q} * 9'd120) + {2'd0, row_q};
        src_bit_s = src_vec_s[bit_idx_s];
        x_s       = X0 + ({6'd0, lane_q} * PITCH) + {{(8 - COL_W){1'b0}}, col_q};
        case (lane_q)
            2'd0:    lane_col_s = COL_DO;
            2'd1:    lane_col_s = COL_RE;
            2'd2:    lane_col_s = COL_MI;
            default: lane_col_s = COL_BG;
        endcase
    end

`ifdef LANE_DRAW_DIRTY_SKIP_EN
    logic [359:0] prev_snap_q;
    logic         prev_valid_q;

    // Row skip decision: unchanged against the last fully drawn frame.
    always_comb begin
        if (prev_valid_q) begin
            skip_s = (src_bit_s == prev_snap_q[bit_idx_s]);
        end else begin
            skip_s = 1'b0;
        end
    end

    // Remember the snapshot of each completed frame.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_snap_q  <= 360'd0;
            prev_valid_q <= 1'b0;
        end else if ((state_q == S_DRAW) && (state_d == S_DONE)) begin
            prev_snap_q  <= snap_q;
            prev_valid_q <= 1'b1;
        end else begin
            prev_snap_q  <= prev_snap_q;
            prev_valid_q <= prev_valid_q;
        end
    end
`else
    // Without dirty tracking every row is drawn.
    always_comb begin
        skip_s = 1'b0;
    end
`endif

    // FSM, scan counters and next values of the registered VGA outputs.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        row_d        = row_q;
        col_d        = col_q;
        snap_d       = snap_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        frame_done_d = 1'b0;
        step_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                lane_d = 2'd0;
                row_d  = 7'd0;
                col_d  = '0;
                if (frame_tick) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                snap_d  = lane_data;
                step_s  = 1'b1;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (pause) begin
                    step_s = 1'b0;
                end else begin
                    step_s = 1'b1;
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // One scan step: issue (or skip) the current pixel and advance col/row/lane.
        if (step_s) begin
            if (skip_s) begin
                plot_d = 1'b0;
            end else begin
                x_d      = x_s;
                y_d      = row_q;
                colour_d = src_bit_s ? lane_col_s : COL_BG;
                plot_d   = 1'b1;
            end
            if (skip_s || (col_q == COL_LAST)) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = 7'd0;
                    if (lane_q == LANE_LAST) begin
                        lane_d  = 2'd0;
                        state_d = S_DONE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end else begin
                    row_d = row_q + 7'd1;
                end
            end else begin
                col_d = col_q + {{(COL_W - 1){1'b0}}, 1'b1};
            end
        end else begin
            plot_d = 1'b0;
        end

        busy_d   = (state_d != S_IDLE);
        missed_d = missed_q | (frame_tick & (state_q != S_IDLE));
    end

    // State and output registers; reset aborts any scan immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            lane_q       <= 2'd0;
            row_q        <= 7'd0;
            col_q        <= '0;
            snap_q       <= 360'd0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'd0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            missed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            row_q        <= row_d;
            col_q        <= col_d;
            snap_q       <= snap_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            missed_q     <= missed_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign plot        = plot_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign missed_tick = missed_q;

endmodule

// File: tb/tb_lane_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lane_draw_scheduler
//   Directed bench for lane_draw_scheduler with default parameters.
//   Cycle numbering: the cycle in which frame_tick is high is c=0; c=N is the
//   N-th cycle after it. Inputs are driven and outputs sampled 1 ns after
//   each rising edge.
// ---------------------------------------------------------------------------
module tb_lane_draw_scheduler;

    logic         clock = 1'b0;
    logic         resetn;
    logic         frame_tick;
    logic [359:0] lane_data;
    logic         pause;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         plot;
    logic         busy;
    logic         frame_done;
    logic         missed_tick;

    lane_draw_scheduler dut (
        .clock       (clock),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .lane_data   (lane_data),
        .pause       (pause),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .frame_done  (frame_done),
        .missed_tick (missed_tick)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Capture of one scan
    logic [7:0] cap_x [0:2879];
    logic [6:0] cap_y [0:2879];
    logic [2:0] cap_c [0:2879];
    bit         plot_at [0:4000];
    int         n_plot;
    int         first_plot;
    int         last_plot;
    int         done_cyc;
    logic       busy1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model of the scan order (LANE_W=8, X0=50, pitch 20).
    function automatic logic [7:0] ex_x(input int i);
        int l;
        l = i / 960;
        return 8'(50 + l * 20 + (i % 8));
    endfunction

    function automatic logic [6:0] ex_y(input int i);
        return 7'((i % 960) / 8);
    endfunction

    function automatic logic [2:0] ex_c(input int i, input logic [359:0] d);
        int l;
        int r;
        l = i / 960;
        r = (i % 960) / 8;
        if (d[l * 120 + r]) begin
            if (l == 0) return 3'b100;
            else if (l == 1) return 3'b010;
            else return 3'b001;
        end
        return 3'b000;
    endfunction

    // Number of captured pixels differing from the model; first bad index out.
    function automatic int count_bad(input logic [359:0] d, output int first_bad);
        int bad;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 2880; i++) begin
            if (cap_x[i] !== ex_x(i) || cap_y[i] !== ex_y(i) || cap_c[i] !== ex_c(i, d)) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        return bad;
    endfunction

    // Start a scan with the given bitmap and record every cycle until frame_done.
    task automatic scan(input logic [359:0] data, input int pause_at, input int pause_len,
                        input bit toggle);
        n_plot     = 0;
        first_plot = -1;
        last_plot  = -1;
        done_cyc   = -1;
        busy1      = 1'b0;
        for (int i = 0; i < 2880; i++) begin
            cap_x[i] = 8'd0;
            cap_y[i] = 7'd0;
            cap_c[i] = 3'd7;
        end
        lane_data  = data;
        pause      = 1'b0;
        frame_tick = 1'b1;
        for (int c = 1; c <= 4000; c++) begin
            step();
            frame_tick = 1'b0;
            if (c == 1) busy1 = busy;
            plot_at[c] = plot;
            if (plot === 1'b1) begin
                if (n_plot < 2880) begin
                    cap_x[n_plot] = x;
                    cap_y[n_plot] = y;
                    cap_c[n_plot] = colour;
                end
                if (first_plot < 0) first_plot = c;
                last_plot = c;
                n_plot++;
            end
            pause = (c > pause_at) && (c <= pause_at + pause_len);
            if (toggle && c >= 2) lane_data = (c % 2 == 1) ? data : ~data;
            if (frame_done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        pause     = 1'b0;
        lane_data = data;
        if (done_cyc < 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scan_timeout: frame_done not seen within 4000 cycles");
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        frame_tick = 1'b0;
        pause      = 1'b0;
        lane_data  = 360'd0;
        #1;
        n_assert++;
        if ({x, y, colour, plot, busy, frame_done, missed_tick} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%b plot=%b busy=%b done=%b missed=%b, want all 0",
                     x, y, colour, plot, busy, frame_done, missed_tick);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        step();
        n_assert++;
        if ({plot, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got plot=%b busy=%b, want 0 0", plot, busy);
        end
    endtask

    task automatic test_single_bit();
        logic [359:0] d;
        int fb;
        int bad;
        d = 360'd1;
        scan(d, -1, 0, 1'b0);
        n_assert++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_latency: busy at T+1 got %b want 1", busy1);
        end
        n_assert++;
        if (first_plot != 2) begin
            n_fail++;
            $display("FAIL first_plot_cycle: got %0d want 2", first_plot);
        end
        n_assert++;
        if (n_plot != 2880 || last_plot != 2881) begin
            n_fail++;
            $display("FAIL plot_count: got %0d plots ending %0d, want 2880 ending 2881", n_plot, last_plot);
        end
        n_assert++;
        if (done_cyc != 2882) begin
            n_fail++;
            $display("FAIL done_cycle: got %0d want 2882", done_cyc);
        end
        n_assert++;
        if ({cap_x[0], cap_y[0], cap_c[0]} !== {8'd50, 7'd0, 3'b100}) begin
            n_fail++;
            $display("FAIL first_pixel: got x=%0d y=%0d c=%b want 50 0 100", cap_x[0], cap_y[0], cap_c[0]);
        end
        n_assert++;
        if ({cap_x[8], cap_y[8], cap_c[8]} !== {8'd50, 7'd1, 3'b000}) begin
            n_fail++;
            $display("FAIL pixel9: got x=%0d y=%0d c=%b want 50 1 000", cap_x[8], cap_y[8], cap_c[8]);
        end
        n_assert++;
        if ({cap_x[2879], cap_y[2879], cap_c[2879]} !== {8'd97, 7'd119, 3'b000}) begin
            n_fail++;
            $display("FAIL last_pixel: got x=%0d y=%0d c=%b want 97 119 000",
                     cap_x[2879], cap_y[2879], cap_c[2879]);
        end
        bad = count_bad(d, fb);
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL seq_single: %0d bad pixels, first at %0d want 0", bad, fb);
        end
        step();
        n_assert++;
        if ({busy, frame_done, plot} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_done: got busy=%b done=%b plot=%b want 000", busy, frame_done, plot);
        end
    endtask

    task automatic test_lane2_bottom();
        logic [359:0] d;
        int fb;
        int bad;
        d = 360'd0;
        d[359] = 1'b1;
        scan(d, -1, 0, 1'b0);
        n_assert++;
        if ({cap_x[2872], cap_y[2872], cap_c[2872]} !== {8'd90, 7'd119, 3'b001}) begin
            n_fail++;
            $display("FAIL lane2_first_tile: got x=%0d y=%0d c=%b want 90 119 001",
                     cap_x[2872], cap_y[2872], cap_c[2872]);
        end
        n_assert++;
        if ({cap_x[2879], cap_c[2879], cap_c[2871]} !== {8'd97, 3'b001, 3'b000}) begin
            n_fail++;
            $display("FAIL lane2_last_tile: got x=%0d c=%b prev_c=%b want 97 001 000",
                     cap_x[2879], cap_c[2879], cap_c[2871]);
        end
        bad = count_bad(d, fb);
        n_assert++;
        if (bad != 0 || n_plot != 2880) begin
            n_fail++;
            $display("FAIL seq_lane2: %0d bad pixels (first %0d), %0d plots, want 0 and 2880", bad, fb, n_plot);
        end
    endtask

    task automatic test_snapshot();
        logic [359:0] d;
        int fb;
        int bad;
        for (int i = 0; i < 360; i++) d[i] = (i % 5 == 0) || (i % 11 == 3);
        scan(d, -1, 0, 1'b1);
        bad = count_bad(d, fb);
        n_assert++;
        if (bad != 0 || n_plot != 2880) begin
            n_fail++;
            $display("FAIL seq_snapshot: %0d bad pixels (first %0d), %0d plots, want 0 and 2880", bad, fb, n_plot);
        end
    endtask

    task automatic test_pause();
        logic [359:0] d;
        int fb;
        int bad;
        for (int i = 0; i < 360; i++) d[i] = (i % 3 == 1);
        scan(d, 100, 5, 1'b0);
        n_assert++;
        if (plot_at[101] !== 1'b1 || plot_at[107] !== 1'b1 ||
            {plot_at[102], plot_at[103], plot_at[104], plot_at[105], plot_at[106]} !== 5'b00000) begin
            n_fail++;
            $display("FAIL pause_gap: plot c101..107 got %b%b%b%b%b%b%b want 1000001",
                     plot_at[101], plot_at[102], plot_at[103], plot_at[104], plot_at[105],
                     plot_at[106], plot_at[107]);
        end
        n_assert++;
        if (n_plot != 2880 || first_plot != 2 || last_plot != 2886) begin
            n_fail++;
            $display("FAIL pause_length: got %0d plots over c%0d..c%0d want 2880 over c2..c2886",
                     n_plot, first_plot, last_plot);
        end
        bad = count_bad(d, fb);
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL seq_pause: %0d bad pixels, first at %0d want 0", bad, fb);
        end
        n_assert++;
        if (done_cyc != 2887) begin
            n_fail++;
            $display("FAIL pause_done: got %0d want 2887", done_cyc);
        end
    endtask

    task automatic test_missed();
        int done_c;
        int extra_plots;
        lane_data  = 360'd5;
        frame_tick = 1'b1;
        done_c     = -1;
        for (int c = 1; c <= 4000; c++) begin
            step();
            frame_tick = (c == 10);
            if (frame_done === 1'b1) begin
                done_c = c;
                break;
            end
        end
        n_assert++;
        if (done_c != 2882 || missed_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL missed_scan: done at %0d missed=%b want 2882 1", done_c, missed_tick);
        end
        extra_plots = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (plot !== 1'b0 || busy !== 1'b0) extra_plots++;
        end
        n_assert++;
        if (extra_plots != 0) begin
            n_fail++;
            $display("FAIL no_queued_scan: %0d busy/plot cycles after done want 0", extra_plots);
        end
        scan(360'd5, -1, 0, 1'b0);
        n_assert++;
        if (busy1 !== 1'b1 || done_cyc != 2882 || missed_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL rescan_after_missed: busy1=%b done=%0d missed=%b want 1 2882 1",
                     busy1, done_cyc, missed_tick);
        end
    endtask

    task automatic test_reset_mid_scan();
        int bad_cycles;
        lane_data  = 360'hFF;
        frame_tick = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            step();
            frame_tick = 1'b0;
        end
        n_assert++;
        if ({plot, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_scan_active: got plot=%b busy=%b want 1 1", plot, busy);
        end
        resetn = 1'b0;
        #1;
        n_assert++;
        if ({plot, busy, missed_tick, x} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got plot=%b busy=%b missed=%b x=%0d want 0 0 0 0",
                     plot, busy, missed_tick, x);
        end
        step();
        resetn = 1'b1;
        bad_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (plot !== 1'b0 || busy !== 1'b0) bad_cycles++;
        end
        n_assert++;
        if (bad_cycles != 0) begin
            n_fail++;
            $display("FAIL scan_aborted: %0d active cycles after reset want 0", bad_cycles);
        end
    endtask

    task automatic test_tick_in_done();
        int bad_cycles;
        lane_data  = 360'd3;
        frame_tick = 1'b1;
        for (int c = 1; c <= 2881; c++) begin
            step();
            frame_tick = (c == 2881);
        end
        step();
        frame_tick = 1'b0;
        n_assert++;
        if ({frame_done, missed_tick} !== 2'b11) begin
            n_fail++;
            $display("FAIL tick_in_done: got done=%b missed=%b want 1 1", frame_done, missed_tick);
        end
        bad_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (plot !== 1'b0 || busy !== 1'b0) bad_cycles++;
        end
        n_assert++;
        if (bad_cycles != 0) begin
            n_fail++;
            $display("FAIL done_tick_dropped: %0d active cycles want 0", bad_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_lane2_bottom();
        test_snapshot();
        test_pause();
        test_missed();
        test_reset_mid_scan();
        test_tick_in_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
